// File: rtl/link_pkg.sv
// Shared opcodes, payload/frame widths and scheduler state encoding for the board-to-board link.
// FRAME_BITS is 18 by default and 19 when LINK_PARITY_EN is defined.
package link_pkg;

    localparam int PAYLOAD_W = 16;

`ifdef LINK_PARITY_EN
    localparam int FRAME_BITS = PAYLOAD_W + 3;
`else
    localparam int FRAME_BITS = PAYLOAD_W + 2;
`endif

    localparam logic [3:0] OP_CONNECT = 4'h1;
    localparam logic [3:0] OP_START   = 4'h2;
    localparam logic [3:0] OP_FINISH  = 4'h3;
    localparam logic [3:0] OP_CELL    = 4'h4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic [3:0] op,
        input logic [3:0] row,
        input logic [3:0] col,
        input logic [3:0] val
    );
        return {op, row, col, val};
    endfunction

endpackage

// File: rtl/link_tx_scheduler_if.sv
// Request, cell-handshake and serial-line signals of the link TX scheduler.
// master = stage controller / board datapath side, slave = the scheduler.
interface link_tx_scheduler_if;

    logic       req_connect;
    logic       req_start;
    logic       req_finish;
    logic       cell_valid;
    logic [3:0] cell_row;
    logic [3:0] cell_col;
    logic [3:0] cell_val;
    logic       cell_ready;
    logic       tx;
    logic       tx_busy;
    logic       frame_sent;

    modport master (
        output req_connect, req_start, req_finish,
        output cell_valid, cell_row, cell_col, cell_val,
        input  cell_ready, tx, tx_busy, frame_sent
    );

    modport slave (
        input  req_connect, req_start, req_finish,
        input  cell_valid, cell_row, cell_col, cell_val,
        output cell_ready, tx, tx_busy, frame_sent
    );

endinterface

// File: rtl/link_serializer.sv
// Frames a 16-bit word (start, LSB-first payload, optional LINK_PARITY_EN parity, stop) onto tx.
// Start bit appears the cycle after load_i; no backpressure, load_i must only arrive while idle.
module link_serializer
    import link_pkg::*;
#(
    parameter int BIT_CYCLES = 2604
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [PAYLOAD_W-1:0] word_i,
    output logic                 tx_o,
    output logic                 frame_sent_o
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  active_q, active_d;
    logic [FRAME_BITS-1:0] frame_w;
    logic                  bit_end;

`ifdef LINK_PARITY_EN
    assign frame_w = {1'b1, ^word_i, word_i, 1'b0};
`else
    assign frame_w = {1'b1, word_i, 1'b0};
`endif

    assign bit_end = active_q && (cyc_q == CYC_LAST);

    always_comb begin
        shift_d  = shift_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        active_d = active_q;
        if (load_i) begin
            shift_d  = frame_w;
            cyc_d    = '0;
            bit_d    = '0;
            active_d = 1'b1;
        end else if (bit_end) begin
            cyc_d   = '0;
            shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
                active_d = 1'b0;
                bit_d    = '0;
            end
        end else if (active_q) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '1;
            cyc_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            active_q <= active_d;
        end
    end

    // Idle line is forced high so a reset mid-frame releases the wire immediately.
    assign tx_o         = active_q ? shift_q[0] : 1'b1;
    assign frame_sent_o = bit_end && (bit_q == BIT_LAST);

endmodule

// File: rtl/link_tx_scheduler.sv
// Fixed-priority (FINISH > START > CONNECT > CELL) TX scheduler; LINK_PARITY_EN adds a parity bit.
// Control pulse -> start bit in 2 cycles, cell accept -> 1 cycle; cell_ready low while busy or control pending.
module link_tx_scheduler
    import link_pkg::*;
#(
    parameter int BIT_CYCLES = 2604,
    parameter int GAP_BITS   = 2
) (
    input  logic               clk,
    input  logic               reset,
    link_tx_scheduler_if.slave lnk
);

    localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
    localparam int GW         = $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_e               state_q, state_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 fin_q, fin_d;
    logic                 sta_q, sta_d;
    logic                 con_q, con_d;
    logic                 ctl_pend, gap_done, grant_ok;
    logic                 gnt_fin, gnt_sta, gnt_con, cell_fire, load;
    logic [PAYLOAD_W-1:0] word;
    logic                 ser_tx, ser_sent;

    assign ctl_pend = fin_q | sta_q | con_q;
    assign gap_done = (state_q == GAP) && (gap_q == GAP_LAST);

    // Granting in the last gap cycle lets queued control frames run at the minimum spacing.
    assign grant_ok  = (state_q == IDLE) || gap_done;
    assign gnt_fin   = grant_ok && fin_q;
    assign gnt_sta   = grant_ok && !fin_q && sta_q;
    assign gnt_con   = grant_ok && !fin_q && !sta_q && con_q;
    assign cell_fire = lnk.cell_valid && lnk.cell_ready;
    assign load      = gnt_fin || gnt_sta || gnt_con || cell_fire;

    // A pulse landing in the grant cycle re-arms the flag for one more frame.
    assign fin_d = (fin_q && !gnt_fin) || lnk.req_finish;
    assign sta_d = (sta_q && !gnt_sta) || lnk.req_start;
    assign con_d = (con_q && !gnt_con) || lnk.req_connect;

    always_comb begin
        word = pack_payload(OP_CELL, lnk.cell_row, lnk.cell_col, lnk.cell_val);
        if (gnt_fin) begin
            word = pack_payload(OP_FINISH, 4'h0, 4'h0, 4'h0);
        end else if (gnt_sta) begin
            word = pack_payload(OP_START, 4'h0, 4'h0, 4'h0);
        end else if (gnt_con) begin
            word = pack_payload(OP_CONNECT, 4'h0, 4'h0, 4'h0);
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (load) state_d = SHIFT;
            end
            SHIFT: begin
                if (ser_sent) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_done) begin
                    state_d = load ? SHIFT : IDLE;
                    gap_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= '0;
            fin_q   <= 1'b0;
            sta_q   <= 1'b0;
            con_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            fin_q   <= fin_d;
            sta_q   <= sta_d;
            con_q   <= con_d;
        end
    end

    link_serializer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_ser (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .word_i       (word),
        .tx_o         (ser_tx),
        .frame_sent_o (ser_sent)
    );

    assign lnk.cell_ready = (state_q == IDLE) && !ctl_pend;
    assign lnk.tx         = ser_tx;
    assign lnk.tx_busy    = (state_q != IDLE);
    assign lnk.frame_sent = ser_sent;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed bench for link_tx_scheduler at BIT_CYCLES=4, GAP_BITS=2; frames are decoded from tx.
// Cycle k is the interval after the k-th rising edge; inputs change 1 time unit after it, outputs are read at the falling edge.
module tb_link_tx_scheduler;

    localparam int BC = 4;
    localparam int GB = 2;
`ifdef LINK_PARITY_EN
    localparam int FB = 19;
`else
    localparam int FB = 18;
`endif
    localparam int FC      = FB * BC;
    localparam int GC      = GB * BC;
    localparam int SPACING = FC + GC;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    link_tx_scheduler_if lnk();

    link_tx_scheduler #(
        .BIT_CYCLES (BC),
        .GAP_BITS   (GB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lnk   (lnk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Decodes one frame from tx; s = first start-bit cycle, sent = cycle of the last frame_sent pulse.
    task automatic recv(output logic [15:0] w, output int s, output int sent, output int nsent,
                        output bit shape_ok, output logic par, output logic stp);
        logic [FB-1:0] bits;
        bit got;
        got = 0; s = -1; sent = -1; nsent = 0; shape_ok = 1; bits = '0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (lnk.tx === 1'b0) got = 1;
        end
        if (got) begin
            s = cyc;
            for (int j = 0; j < FC; j++) begin
                if (j > 0) @(negedge clk);
                if (j % BC == 0) bits[j / BC] = lnk.tx;
                else if (lnk.tx !== bits[j / BC]) shape_ok = 0;
                if (lnk.tx_busy !== 1'b1) shape_ok = 0;
                if (lnk.frame_sent === 1'b1) begin
                    nsent++;
                    sent = cyc;
                end
            end
        end
        w   = bits[16:1];
        par = bits[FB-2];
        stp = bits[FB-1];
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        lnk.req_start = 1'b1;
        tick;
        lnk.req_start = 1'b0;
        @(negedge clk);
        n_chk++; if (lnk.tx !== 1'b1) $display("FAIL rst_tx got %b want 1", lnk.tx); else n_pass++;
        n_chk++; if (lnk.tx_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", lnk.tx_busy); else n_pass++;
        n_chk++; if (lnk.frame_sent !== 1'b0) $display("FAIL rst_sent got %b want 0", lnk.frame_sent); else n_pass++;
        n_chk++; if (lnk.cell_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", lnk.cell_ready); else n_pass++;
        tick;
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if (lnk.cell_ready !== 1'b1) $display("FAIL rst_no_pending got %b want 1", lnk.cell_ready); else n_pass++;
    endtask

    task automatic test_single_start;
        logic [15:0] w; int s, sent, ns, fall; bit shp; logic par, stp;
        while (cyc < 10) tick;
        lnk.req_start = 1'b1;
        tick;
        lnk.req_start = 1'b0;
        recv(w, s, sent, ns, shp, par, stp);
        n_chk++; if (s != 12) $display("FAIL start_txlow got %0d want 12", s); else n_pass++;
        n_chk++; if (w !== 16'h2000) $display("FAIL start_word got %h want 2000", w); else n_pass++;
        n_chk++; if (stp !== 1'b1) $display("FAIL start_stop got %b want 1", stp); else n_pass++;
        n_chk++; if (!shp) $display("FAIL start_shape got 0 want 1"); else n_pass++;
        n_chk++; if (sent != 12 + FC - 1 || ns != 1) $display("FAIL start_sent got %0d x%0d want %0d x1", sent, ns, 12 + FC - 1); else n_pass++;
`ifdef LINK_PARITY_EN
        n_chk++; if (par !== 1'b1) $display("FAIL start_parity got %b want 1", par); else n_pass++;
`endif
        fall = -1;
        for (int k = 0; k < 50 && fall < 0; k++) begin
            @(negedge clk);
            if (lnk.tx_busy === 1'b0) fall = cyc;
        end
        n_chk++; if (fall != 12 + SPACING) $display("FAIL start_busy_fall got %0d want %0d", fall, 12 + SPACING); else n_pass++;
    endtask

    task automatic test_priority;
        logic [15:0] w; int s, sent, ns, n; bit shp; logic par, stp;
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h3000; exp_w[1] = 16'h2000; exp_w[2] = 16'h1000;
        tick;
        n = cyc;
        lnk.req_connect = 1'b1; lnk.req_start = 1'b1; lnk.req_finish = 1'b1;
        tick;
        lnk.req_connect = 1'b0; lnk.req_start = 1'b0; lnk.req_finish = 1'b0;
        for (int f = 0; f < 3; f++) begin
            recv(w, s, sent, ns, shp, par, stp);
            n_chk++; if (w !== exp_w[f] || !shp || stp !== 1'b1) $display("FAIL prio_word%0d got %h want %h", f, w, exp_w[f]); else n_pass++;
            n_chk++; if (s != n + 2 + f * SPACING) $display("FAIL prio_start%0d got %0d want %0d", f, s, n + 2 + f * SPACING); else n_pass++;
        end
    endtask

    task automatic test_cell_wait;
        logic [15:0] w; int s, sent, ns, n, r; bit shp; logic par, stp;
        repeat (GC + 8) tick;
        n = cyc;
        lnk.req_start = 1'b1;
        tick;
        lnk.req_start = 1'b0;
        lnk.cell_valid = 1'b1; lnk.cell_row = 4'd3; lnk.cell_col = 4'd7; lnk.cell_val = 4'd9;
        @(negedge clk);
        n_chk++; if (lnk.cell_ready !== 1'b0) $display("FAIL cell_hold got %b want 0", lnk.cell_ready); else n_pass++;
        recv(w, s, sent, ns, shp, par, stp);
        n_chk++; if (w !== 16'h2000 || s != n + 2) $display("FAIL cell_ctl_first got %h@%0d want 2000@%0d", w, s, n + 2); else n_pass++;
        r = -1;
        for (int k = 0; k < 50 && r < 0; k++) begin
            @(negedge clk);
            if (lnk.cell_ready === 1'b1) r = cyc;
        end
        n_chk++; if (r != n + 2 + SPACING) $display("FAIL cell_ready_rise got %0d want %0d", r, n + 2 + SPACING); else n_pass++;
        tick;
        lnk.cell_valid = 1'b0;
        recv(w, s, sent, ns, shp, par, stp);
        n_chk++; if (w !== 16'h4379 || !shp) $display("FAIL cell_word got %h want 4379", w); else n_pass++;
        n_chk++; if (s != n + 3 + SPACING) $display("FAIL cell_start got %0d want %0d", s, n + 3 + SPACING); else n_pass++;
        n_chk++; if (sent != n + 2 + SPACING + FC) $display("FAIL cell_sent got %0d want %0d", sent, n + 2 + SPACING + FC); else n_pass++;
`ifdef LINK_PARITY_EN
        n_chk++; if (par !== 1'b0) $display("FAIL cell_parity got %b want 0", par); else n_pass++;
`endif
    endtask

    task automatic test_cell_range;
        logic [15:0] w; int s, sent, ns, n; bit shp; logic par, stp;
        repeat (GC + 8) tick;
        n = cyc;
        lnk.cell_valid = 1'b1; lnk.cell_row = 4'd15; lnk.cell_col = 4'd12; lnk.cell_val = 4'd0;
        @(negedge clk);
        n_chk++; if (lnk.cell_ready !== 1'b1) $display("FAIL range_ready got %b want 1", lnk.cell_ready); else n_pass++;
        tick;
        lnk.cell_valid = 1'b0;
        recv(w, s, sent, ns, shp, par, stp);
        n_chk++; if (s != n + 1) $display("FAIL range_start got %0d want %0d", s, n + 1); else n_pass++;
        n_chk++; if (w !== 16'h4FC0 || stp !== 1'b1) $display("FAIL range_word got %h want 4fc0", w); else n_pass++;
    endtask

    task automatic test_merge;
        logic [15:0] w; int s, sent, ns, n, extra; bit shp; logic par, stp;
        repeat (GC + 8) tick;
        n = cyc;
        lnk.req_connect = 1'b1;
        tick;
        lnk.req_connect = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (15) tick;
            lnk.req_connect = 1'b1;
            tick;
            lnk.req_connect = 1'b0;
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (lnk.frame_sent === 1'b1) break;
        end
        recv(w, s, sent, ns, shp, par, stp);
        n_chk++; if (w !== 16'h1000) $display("FAIL merge_word got %h want 1000", w); else n_pass++;
        n_chk++; if (s != n + 2 + SPACING) $display("FAIL merge_start got %0d want %0d", s, n + 2 + SPACING); else n_pass++;
        extra = 0;
        repeat (GC) @(negedge clk);
        for (int k = 0; k < 2 * SPACING; k++) begin
            @(negedge clk);
            if (lnk.tx !== 1'b1 || lnk.tx_busy !== 1'b0) extra++;
        end
        n_chk++; if (extra != 0) $display("FAIL merge_no_third got %0d busy cycles want 0", extra); else n_pass++;
    endtask

    task automatic test_regrant;
        logic [15:0] w; int s, sent, ns, n, extra; bit shp; logic par, stp;
        repeat (GC + 8) tick;
        n = cyc;
        lnk.req_start = 1'b1;
        tick;
        tick;
        lnk.req_start = 1'b0;
        recv(w, s, sent, ns, shp, par, stp);
        n_chk++; if (w !== 16'h2000 || s != n + 2) $display("FAIL regrant_first got %h@%0d want 2000@%0d", w, s, n + 2); else n_pass++;
        recv(w, s, sent, ns, shp, par, stp);
        n_chk++; if (w !== 16'h2000 || s != n + 2 + SPACING) $display("FAIL regrant_second got %h@%0d want 2000@%0d", w, s, n + 2 + SPACING); else n_pass++;
        repeat (GC) @(negedge clk);
        extra = 0;
        for (int k = 0; k < SPACING + 8; k++) begin
            @(negedge clk);
            if (lnk.tx !== 1'b1 || lnk.tx_busy !== 1'b0) extra++;
        end
        n_chk++; if (extra != 0) $display("FAIL regrant_no_third got %0d busy cycles want 0", extra); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n, extra;
        repeat (GC + 8) tick;
        n = cyc;
        lnk.req_finish = 1'b1;
        tick;
        lnk.req_finish = 1'b0;
        lnk.req_connect = 1'b1;
        tick;
        lnk.req_connect = 1'b0;
        while (cyc < n + 22) tick;
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (lnk.tx_busy !== 1'b1 || lnk.tx !== 1'b0) $display("FAIL midrst_before got busy=%b tx=%b want 1/0", lnk.tx_busy, lnk.tx); else n_pass++;
        tick;
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if (lnk.tx !== 1'b1) $display("FAIL midrst_tx got %b want 1", lnk.tx); else n_pass++;
        n_chk++; if (lnk.tx_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", lnk.tx_busy); else n_pass++;
        extra = 0;
        for (int k = 0; k < 2 * SPACING; k++) begin
            @(negedge clk);
            if (lnk.tx !== 1'b1 || lnk.tx_busy !== 1'b0) extra++;
        end
        n_chk++; if (extra != 0) $display("FAIL midrst_no_resume got %0d busy cycles want 0", extra); else n_pass++;
    endtask

    initial begin
        lnk.req_connect = 1'b0;
        lnk.req_start   = 1'b0;
        lnk.req_finish  = 1'b0;
        lnk.cell_valid  = 1'b0;
        lnk.cell_row    = 4'd0;
        lnk.cell_col    = 4'd0;
        lnk.cell_val    = 4'd0;
        test_reset;
        test_single_start;
        test_priority;
        test_cell_wait;
        test_cell_range;
        test_merge;
        test_regrant;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/link_tx_scheduler.md
# link_tx_scheduler

Transmit-side scheduler for the board-to-board link. It shares one serial TX wire between the game-control requesters (connect, start, game-finish) and the cell-update stream from the board logic. It arbitrates by fixed priority, frames each message and serializes it at a parameterized bit rate. It sits between the stage controller and the board datapath on one side and the inter-board pin on the other.

## Interface
- BIT_CYCLES, default 2604: clock cycles per serial bit; legal range is 2 and above.
- GAP_BITS, default 2: idle-high bit times inserted after every frame; legal range is 1 and above.
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- req_connect, input, 1: one-cycle request to send a CONNECT message.
- req_start, input, 1: one-cycle request to send a START message.
- req_finish, input, 1: one-cycle request to send a FINISH message.
- cell_valid, input, 1: a cell update is offered.
- cell_row, input, 4: row of the offered cell, 0–8.
- cell_col, input, 4: column of the offered cell, 0–8.
- cell_val, input, 4: value of the offered cell; 0 means clear, 1–9 are digits.
- cell_ready, output, 1: the scheduler accepts a cell update this cycle.
- tx, output, 1: serial line; it idles high.
- tx_busy, output, 1: a frame or its trailing gap is in progress.
- frame_sent, output, 1: one-cycle pulse at the end of each stop bit.

## Operation
- Each control request pulse sets its own pending flag. Repeated pulses while the flag is already set merge into one frame.
- A pending flag clears in the cycle its frame is granted. A pulse that arrives in that same cycle re-sets the flag, so a second frame follows.
- Priority order is FINISH, then START, then CONNECT, then CELL.
- cell_ready = (state == IDLE) && no control flag pending. A cell transfer happens when cell_valid && cell_ready are both high.
- Frame format:
  - Start bit 0.
  - 16-bit payload, sent LSB first: {opcode[3:0], row[3:0], col[3:0], val[3:0]}.
  - Stop bit 1.
- Opcodes are CONNECT=4'h1, START=4'h2, FINISH=4'h3, CELL=4'h4. Control frames carry row, col and val all equal to 0.
- States and transitions:
  - IDLE: on a grant, latch the payload and go to SHIFT.
  - SHIFT: a bit counter and a cycle counter run. After the last cycle of the stop bit, go to GAP.
  - GAP: tx is held at 1 for GAP_BITS*BIT_CYCLES cycles, then go to IDLE.
- The cycle counter wraps from BIT_CYCLES-1 to 0 and advances the bit index. The bit index runs 0..17 (0..18 with parity).
- Input values are not range-checked. A row or column value of 9–15 is transmitted exactly as given.
- Values after reset:
  - State IDLE; all pending flags cleared.
  - tx=1, tx_busy=0, frame_sent=0, cell_ready=1.
- Reset mid-frame aborts the frame. tx is 1 from the next edge and nothing is resumed.

## Timing
- Control pulse at cycle N: pending is set at N+1, the grant happens at N+1, and the start bit is on tx from N+2.
- Cell accept at cycle N (valid && ready): the start bit is on tx from N+1.
- Each bit holds for exactly BIT_CYCLES cycles. A frame occupies 18*BIT_CYCLES cycles, or 19*BIT_CYCLES with parity.
- frame_sent pulses in the last cycle of the stop bit.
- tx_busy is high from the first start-bit cycle through the last GAP cycle.
- Back-to-back frames start on the cycle after GAP ends. The minimum spacing is (18+GAP_BITS)*BIT_CYCLES cycles.
- Requests that arrive during SHIFT or GAP wait as pending and are served by priority at the next IDLE.

## Configuration
- LINK_PARITY_EN:
  - When defined: an even-parity bit over the 16 payload bits is inserted between the payload and the stop bit, giving a 19-bit frame.
  - When undefined: the frame is 18 bits, with no parity logic.

## Structure
- Package link_pkg holds:
  - the opcode constants;
  - the payload width of 16;
  - the FRAME_BITS localparam, which depends on LINK_PARITY_EN;
  - the state encoding IDLE/SHIFT/GAP.
- Sub-module link_serializer contains the shift register, the bit and cycle counters, the parity logic and the tx/frame_sent outputs.
  - It is driven by a load strobe plus a 16-bit word.
- The top level holds the pending flags, the priority arbiter, the cell handshake and the GAP timer.

## Test plan
All scenarios use BIT_CYCLES=4 and GAP_BITS=2 unless stated.
- Single req_start at cycle 10:
  - tx goes low at cycle 12.
  - The payload is 16'h2000, sent LSB first.
  - frame_sent fires at cycle 83; tx_busy falls at cycle 92.
- req_connect, req_start and req_finish pulsed in the same cycle: frames go out in the order FINISH, START, CONNECT, each separated by 8 idle cycles.
- Cell offer with row=3, col=7, val=9 and cell_valid held high while a START request is pending:
  - cell_ready stays 0 until the START frame's gap ends.
  - The cell frame then carries 16'h4379.
- req_connect pulsed three times during one frame: exactly one extra CONNECT frame follows.
- Reset asserted at the 5th payload bit: tx=1 and tx_busy=0 from the next cycle, and no frame resumes after reset releases.
- With LINK_PARITY_EN defined and payload 16'h4379 (eight 1s): the parity bit is 0 and frame_sent is delayed by 4 cycles.
